// File: rtl/dds_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_mc_if
// Description : Bundle for the multi-channel DDS. Carries the configuration
//               write port, run control pulses and the tagged sample stream.
//               master : drives config/control, receives samples (testbench,
//                        host logic)
//               slave  : the DDS core
// Ports       : i_cfg_we/i_cfg_ch/i_cfg_sel/i_cfg_data  config write
//               i_start/i_stop/i_sync                     run control pulses
//               o_sample/o_ch/o_valid                     tagged sample stream
//               o_busy                                    activity flag
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_mc_if #(
  parameter int CH_W        = 2,
  parameter int PHASE_WIDTH = 32,
  parameter int SIG_WIDTH   = 16
);
  logic                          i_cfg_we;
  logic [CH_W-1:0]               i_cfg_ch;
  logic [1:0]                    i_cfg_sel;
  logic [PHASE_WIDTH-1:0]        i_cfg_data;
  logic                          i_start;
  logic                          i_stop;
  logic                          i_sync;
  logic signed [SIG_WIDTH-1:0]   o_sample;
  logic [CH_W-1:0]               o_ch;
  logic                          o_valid;
  logic                          o_busy;

  modport master (
    output i_cfg_we, i_cfg_ch, i_cfg_sel, i_cfg_data, i_start, i_stop, i_sync,
    input  o_sample, o_ch, o_valid, o_busy
  );

  modport slave (
    input  i_cfg_we, i_cfg_ch, i_cfg_sel, i_cfg_data, i_start, i_stop, i_sync,
    output o_sample, o_ch, o_valid, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/dds_mc.sv
`default_nettype none
// ============================================================================
// Module      : dds_mc
// Description : Time-multiplexed multi-channel DDS. Each channel owns a phase
//               accumulator, tuning word, phase offset, amplitude and enable.
//               Channels are serviced round-robin, one slot per clock, through
//               a 4-stage pipeline built around a quarter-wave sine ROM.
//               S1 : phase = acc + offset, LUT address, channel tag
//               S2 : quarter-wave fold and registered ROM read
//               S3 : sign restore for the lower half-wave
//               S4 : amplitude scaling, output register
// Ports       : clk      rising-edge clock
//               a_rst_n  asynchronous active-low reset
//               bus      dds_mc_if.slave (config, control, sample stream)
// Revision    : 1.0 - initial release
// ============================================================================
module dds_mc #(
  parameter int N_CH           = 4,
  parameter int SIG_WIDTH      = 16,
  parameter int PHASE_WIDTH    = 32,
  parameter int LUT_ADDR_WIDTH = 10,
  parameter int AMP_WIDTH      = 16,
  parameter int CH_W           = $clog2(N_CH)
) (
  input  logic    clk,
  input  logic    a_rst_n,
  dds_mc_if.slave bus
);

  localparam int QW     = LUT_ADDR_WIDTH - 2;       // quarter-wave index width
  localparam int Q      = 1 << QW;                  // quarter-wave length
  localparam int IDX_W  = QW + 1;                   // ROM index covers 0..Q
  localparam int PROD_W = SIG_WIDTH + AMP_WIDTH + 1;
  localparam int SHIFT  = PHASE_WIDTH - LUT_ADDR_WIDTH;

  // --------------------------------------------------------------------------
  // Sine ROM contents, evaluated at elaboration. A Taylor series over the
  // first quadrant keeps the build independent of tool math libraries.
  // --------------------------------------------------------------------------
  function automatic real sin_first_quadrant(input real x);
    real term;
    real sum;
    term = x;
    sum  = x;
    for (int n = 1; n < 12; n++) begin
      term = -term * x * x / real'((2 * n) * (2 * n + 1));
      sum  = sum + term;
    end
    return sum;
  endfunction

  function automatic logic signed [SIG_WIDTH-1:0] rom_val(input int k);
    real full;
    real x;
    full = real'((longint'(1) << (SIG_WIDTH - 1)) - 1);
    x    = 3.14159265358979323846 * real'(k) / real'(2 * Q);
    return SIG_WIDTH'($rtoi(full * sin_first_quadrant(x) + 0.5));
  endfunction

  logic signed [SIG_WIDTH-1:0] rom [Q+1];

  for (genvar k = 0; k <= Q; k++) begin : g_rom
    localparam logic signed [SIG_WIDTH-1:0] ROM_VAL = rom_val(k);
    assign rom[k] = ROM_VAL;
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic                          running_q, running_d;
  logic [CH_W-1:0]               ptr_q, ptr_d;

  logic [PHASE_WIDTH-1:0]        acc_q [N_CH];
  logic [PHASE_WIDTH-1:0]        acc_d [N_CH];
  logic [PHASE_WIDTH-1:0]        ftw_q [N_CH];
  logic [PHASE_WIDTH-1:0]        ftw_d [N_CH];
  logic [PHASE_WIDTH-1:0]        off_q [N_CH];
  logic [PHASE_WIDTH-1:0]        off_d [N_CH];
  logic [AMP_WIDTH-1:0]          amp_q [N_CH];
  logic [AMP_WIDTH-1:0]          amp_d [N_CH];
  logic [N_CH-1:0]               en_q, en_d;

  // "issued" tracks every slot (feeds o_busy); "valid" only enabled ones
  logic                          s1_issued_q, s1_issued_d;
  logic                          s1_valid_q, s1_valid_d;
  logic [CH_W-1:0]               s1_ch_q, s1_ch_d;
  logic [AMP_WIDTH-1:0]          s1_amp_q, s1_amp_d;
  logic [LUT_ADDR_WIDTH-1:0]     s1_addr_q, s1_addr_d;

  logic                          s2_issued_q, s2_issued_d;
  logic                          s2_valid_q, s2_valid_d;
  logic [CH_W-1:0]               s2_ch_q, s2_ch_d;
  logic [AMP_WIDTH-1:0]          s2_amp_q, s2_amp_d;
  logic                          s2_neg_q, s2_neg_d;
  logic signed [SIG_WIDTH-1:0]   s2_rom_q, s2_rom_d;

  logic                          s3_issued_q, s3_issued_d;
  logic                          s3_valid_q, s3_valid_d;
  logic [CH_W-1:0]               s3_ch_q, s3_ch_d;
  logic [AMP_WIDTH-1:0]          s3_amp_q, s3_amp_d;
  logic signed [SIG_WIDTH-1:0]   s3_sine_q, s3_sine_d;

  logic                          s4_issued_q, s4_issued_d;
  logic                          out_valid_q, out_valid_d;
  logic [CH_W-1:0]               out_ch_q, out_ch_d;
  logic signed [SIG_WIDTH-1:0]   out_sample_q, out_sample_d;

  // --------------------------------------------------------------------------
  // Run control and slot pointer
  // --------------------------------------------------------------------------
  always_comb begin
    running_d = running_q;
    ptr_d     = ptr_q;
    if (running_q) begin
      ptr_d = ptr_q + CH_W'(1);
    end
    // stop has priority; start only matters while idle
    if (bus.i_stop) begin
      running_d = 1'b0;
    end else if (bus.i_start && !running_q) begin
      running_d = 1'b1;
      ptr_d     = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel registers. The slot increment is computed from the old FTW;
  // an accumulator clear (control bit1 or i_sync) overrides it.
  // --------------------------------------------------------------------------
  always_comb begin
    acc_d = acc_q;
    ftw_d = ftw_q;
    off_d = off_q;
    amp_d = amp_q;
    en_d  = en_q;
    for (int c = 0; c < N_CH; c++) begin
      if (running_q && (ptr_q == CH_W'(c)) && en_q[c]) begin
        acc_d[c] = acc_q[c] + ftw_q[c];
      end
      if (bus.i_cfg_we && (bus.i_cfg_ch == CH_W'(c))) begin
        case (bus.i_cfg_sel)
          2'd0:    ftw_d[c] = bus.i_cfg_data;
          2'd1:    off_d[c] = bus.i_cfg_data;
          2'd2:    amp_d[c] = bus.i_cfg_data[AMP_WIDTH-1:0];
          default: begin
            en_d[c] = bus.i_cfg_data[0];
            if (bus.i_cfg_data[1]) begin
              acc_d[c] = '0;
            end
          end
        endcase
      end
      if (bus.i_sync) begin
        acc_d[c] = '0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline datapath
  // --------------------------------------------------------------------------
  logic [PHASE_WIDTH-1:0]        phase_sum;
  logic [1:0]                    quad;
  logic [QW-1:0]                 fine_idx;
  logic [IDX_W-1:0]              rom_idx;
  logic signed [PROD_W-1:0]      prod;

  always_comb begin
    // S1: sample uses the pre-increment accumulator
    phase_sum   = acc_q[ptr_q] + off_q[ptr_q];
    s1_addr_d   = LUT_ADDR_WIDTH'(phase_sum >> SHIFT);
    s1_issued_d = running_q;
    s1_valid_d  = running_q && en_q[ptr_q];
    s1_ch_d     = ptr_q;
    s1_amp_d    = amp_q[ptr_q];

    // S2: odd quadrants read the quarter wave backwards
    quad        = s1_addr_q[LUT_ADDR_WIDTH-1 -: 2];
    fine_idx    = s1_addr_q[QW-1:0];
    rom_idx     = quad[0] ? (IDX_W'(Q) - {1'b0, fine_idx}) : {1'b0, fine_idx};
    s2_rom_d    = rom[rom_idx];
    s2_neg_d    = quad[1];
    s2_issued_d = s1_issued_q;
    s2_valid_d  = s1_valid_q;
    s2_ch_d     = s1_ch_q;
    s2_amp_d    = s1_amp_q;

    // S3: lower half-wave is negative
    s3_sine_d   = s2_neg_q ? -s2_rom_q : s2_rom_q;
    s3_issued_d = s2_issued_q;
    s3_valid_d  = s2_valid_q;
    s3_ch_d     = s2_ch_q;
    s3_amp_d    = s2_amp_q;

    // S4: signed sine times unsigned amplitude, floor-scaled back
    prod         = PROD_W'(s3_sine_q) * $signed(PROD_W'({1'b0, s3_amp_q}));
    s4_issued_d  = s3_issued_q;
    out_valid_d  = s3_valid_q;
    out_sample_d = out_sample_q;
    out_ch_d     = out_ch_q;
    if (s3_valid_q) begin
      out_sample_d = SIG_WIDTH'(prod >>> AMP_WIDTH);
      out_ch_d     = s3_ch_q;
    end
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      running_q    <= 1'b0;
      ptr_q        <= '0;
      acc_q        <= '{default: '0};
      ftw_q        <= '{default: '0};
      off_q        <= '{default: '0};
      amp_q        <= '{default: '0};
      en_q         <= '0;
      s1_issued_q  <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_ch_q      <= '0;
      s1_amp_q     <= '0;
      s1_addr_q    <= '0;
      s2_issued_q  <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_ch_q      <= '0;
      s2_amp_q     <= '0;
      s2_neg_q     <= 1'b0;
      s2_rom_q     <= '0;
      s3_issued_q  <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_ch_q      <= '0;
      s3_amp_q     <= '0;
      s3_sine_q    <= '0;
      s4_issued_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_sample_q <= '0;
    end else begin
      running_q    <= running_d;
      ptr_q        <= ptr_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
      off_q        <= off_d;
      amp_q        <= amp_d;
      en_q         <= en_d;
      s1_issued_q  <= s1_issued_d;
      s1_valid_q   <= s1_valid_d;
      s1_ch_q      <= s1_ch_d;
      s1_amp_q     <= s1_amp_d;
      s1_addr_q    <= s1_addr_d;
      s2_issued_q  <= s2_issued_d;
      s2_valid_q   <= s2_valid_d;
      s2_ch_q      <= s2_ch_d;
      s2_amp_q     <= s2_amp_d;
      s2_neg_q     <= s2_neg_d;
      s2_rom_q     <= s2_rom_d;
      s3_issued_q  <= s3_issued_d;
      s3_valid_q   <= s3_valid_d;
      s3_ch_q      <= s3_ch_d;
      s3_amp_q     <= s3_amp_d;
      s3_sine_q    <= s3_sine_d;
      s4_issued_q  <= s4_issued_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_sample_q <= out_sample_d;
    end
  end

  assign bus.o_sample = out_sample_q;
  assign bus.o_ch     = out_ch_q;
  assign bus.o_valid  = out_valid_q;
  assign bus.o_busy   = running_q | s1_issued_q | s2_issued_q | s3_issued_q | s4_issued_q;

endmodule
`default_nettype wire
